reflet_float_mult_pipe: RTL and testbench
=========================================

Name: reflet_float_mult_pipe

Overview:
- Parametrised, fully pipelined mantissa multiplier for the FPU multiply path.
- Replaces the fixed-latency enable/ready multiplier with a configurable-depth pipeline. Uses per-stage valid bits, a valid/ready handshake with back-pressure, a tag sideband and an optional two's-complement mode.
- Accepts one operand pair per cycle and returns products in order. The downstream normaliser can stall it without losing data.

Parameters:
- size, 10, operand width in bits; product width is 2*size.
- stages, 2, pipeline depth; legal range 1..8. Nominal latency is `stages` cycles.
- signed_mode, 0: 0 = unsigned product; 1 = two's-complement product of in1 and in2.
- tag_size, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair on in1/in2/in_tag is valid.
- in_ready  out  1  pipeline can accept an operand pair this cycle.
- in1  in  size  multiplicand.
- in2  in  size  multiplier.
- in_tag  in  tag_size  opaque tag, returned with the product.
- out_valid  out  1  mult/out_tag hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- mult  out  2*size  product.
- out_tag  out  tag_size  tag of the operation presented on mult.
- busy  out  1  at least one stage holds a valid operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits, data registers and tag registers clear to 0.
  - Outputs after reset: out_valid=0, mult=0, out_tag=0, busy=0, in_ready=1.
  - Reset mid-operation discards every in-flight operation; no result is emitted after reset is released.
- Pipeline structure:
  - Stage k (k=0..stages-1) holds valid[k], prod[k] of 2*size bits, and tag[k].
  - The full product is computed combinationally from in1/in2 and captured into stage 0. Later stages carry prod and tag unchanged; they exist for retiming.
- Advance rule, evaluated from the output end:
  - load[stages-1] = !valid[stages-1] || out_ready.
  - load[k] = !valid[k] || load[k+1].
  - in_ready = load[0]. This is a combinational path from out_ready to in_ready and is permitted.
- Stage update on a clock edge where load[k] is high:
  - Stage 0 takes valid[0] <= in_valid && in_ready, together with the new product and in_tag.
  - Stage k>0 takes valid[k] <= valid[k-1], with prod[k-1] and tag[k-1].
  - When load[k] is low, stage k holds all of its contents.
  - A bubble (valid=0) is overwritten freely, so bubbles collapse under stall.
- Output mapping:
  - out_valid = valid[stages-1].
  - mult = prod[stages-1].
  - out_tag = tag[stages-1].
- Handshake rules:
  - A transfer occurs on a clock edge where valid and ready are both high.
  - While out_valid=1 and out_ready=0, mult and out_tag stay stable and out_valid stays 1.
  - The producer may change in1/in2 freely while in_ready=0; inputs are ignored unless a transfer occurs.
- Latency and throughput:
  - An operand accepted at edge N appears with out_valid=1 after edge N+stages-1, i.e. `stages` cycles after presentation, when there is no stall.
  - Sustained throughput is 1 operation per cycle with out_ready held at 1.
  - Capacity is exactly `stages` operations. When full and out_ready=0, in_ready=0.
- Simultaneous events:
  - When full and out_ready=1, the output transfer and a new input acceptance happen on the same edge; the pipeline stays full.
- Arithmetic:
  - signed_mode=0: mult = in1*in2, exact and unsigned, so it never overflows 2*size bits.
  - signed_mode=1: both operands are sign-extended and the product is exact two's complement in 2*size bits.
  - The edge case (-2^(size-1))^2 = 2^(2*size-2) still fits.
- busy = OR of all valid[k].
- Ordering: results always leave in acceptance order; tags are never reordered.

Test Plan:
- Single op, size=10, stages=2, unsigned: in1=3, in2=5, tag=7 accepted at edge 0 -> out_valid=1 after edge 1, mult=15, out_tag=7, busy=0 after consumption.
- Back-to-back with out_ready=1: 8 pairs (i, i+1) for i=0..7 on consecutive cycles -> 8 consecutive out_valid cycles with mult=i*(i+1) in order, in_ready never drops.
- Back-pressure: hold out_ready=0 and push 3 ops, stages=2 -> in_ready=0 after 2 accepted. The third is not taken and mult holds the first product. Release out_ready -> all products delivered in order with no loss or duplication.
- Extremes, unsigned: 1023*1023 -> mult=20'hFF801.
- Signed, signed_mode=1: in1=10'h3FF, in2=10'h002 -> mult=20'hFFFFE. Also 10'h200*10'h200 -> 20'h40000.
- Reset mid-operation: assert reset with 2 ops in flight -> out_valid=0, busy=0 and mult=0 immediately (asynchronous). No stale result appears after release, and a new op completes with normal latency.

Source files
------------

// File: rtl/reflet_float_mult_pipe.sv
// Fully pipelined mantissa multiplier with valid/ready handshake, a tag sideband and
// optional two's-complement products. Bubbles collapse under stall.
module reflet_float_mult_pipe #(
    parameter int unsigned size        = 10,
    parameter int unsigned stages      = 2,
    parameter int unsigned signed_mode = 0,
    parameter int unsigned tag_size    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [size-1:0]       in1,
    input  logic [size-1:0]       in2,
    input  logic [tag_size-1:0]   in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*size-1:0]     mult,
    output logic [tag_size-1:0]   out_tag,
    output logic                  busy
);

    localparam int unsigned ProdW = 2 * size;

    logic [stages-1:0]   valid_q;
    logic [ProdW-1:0]    prod_q [stages];
    logic [tag_size-1:0] tag_q  [stages];
    logic [stages-1:0]   load;
    logic [ProdW-1:0]    product;

    if (signed_mode != 0) begin : g_signed
        logic signed [ProdW-1:0] a_ext;
        logic signed [ProdW-1:0] b_ext;
        assign a_ext   = {{size{in1[size-1]}}, in1};
        assign b_ext   = {{size{in2[size-1]}}, in2};
        // Sign-extended operands make the truncated product exact two's complement.
        assign product = a_ext * b_ext;
    end else begin : g_unsigned
        assign product = {{size{1'b0}}, in1} * {{size{1'b0}}, in2};
    end

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        logic run;
        load = '0;
        run  = !valid_q[stages-1] || out_ready;
        load[stages-1] = run;
        for (int k = int'(stages) - 2; k >= 0; k--) begin
            run     = !valid_q[k] || run;
            load[k] = run;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < int'(stages); k++) begin
                prod_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                prod_q[0]  <= product;
                tag_q[0]   <= in_tag;
            end
            for (int k = 1; k < int'(stages); k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    prod_q[k]  <= prod_q[k-1];
                    tag_q[k]   <= tag_q[k-1];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[stages-1];
    assign mult      = prod_q[stages-1];
    assign out_tag   = tag_q[stages-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_reflet_float_mult_pipe.sv
// Directed bench for reflet_float_mult_pipe: an arithmetic scoreboard checks every presented
// result of the unsigned instance; a second instance covers signed mode.
module tb_reflet_float_mult_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in1 = '0;
    logic [9:0]  in2 = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] mult;
    logic [3:0]  out_tag;
    logic        busy;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [9:0]  s_in1 = '0;
    logic [9:0]  s_in2 = '0;
    logic [3:0]  s_in_tag = '0;
    logic        s_out_valid;
    logic [19:0] s_mult;
    logic [3:0]  s_out_tag;
    logic        s_busy;

    int total = 0;
    int bad   = 0;
    int popped = 0;

    typedef struct {
        logic [19:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    reflet_float_mult_pipe #(.size(10), .stages(2), .signed_mode(0), .tag_size(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .mult(mult), .out_tag(out_tag), .busy(busy)
    );

    reflet_float_mult_pipe #(.size(10), .stages(2), .signed_mode(1), .tag_size(4)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in1(s_in1), .in2(s_in2), .in_tag(s_in_tag), .out_valid(s_out_valid),
        .out_ready(1'b1), .mult(s_mult), .out_tag(s_out_tag), .busy(s_busy)
    );

    function automatic logic [19:0] ref_mult(input logic [9:0] a, input logic [9:0] b,
                                             input bit sgn);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[9]) sa = sa - 1024;
        if (sgn && b[9]) sb = sb - 1024;
        p = sa * sb;
        return p[19:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs are checked at the falling edge; the handshakes decided then take
    // effect on the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("no_unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("sb_mult", {12'd0, mult}, {12'd0, q[0].p});
                    check("sb_tag", {28'd0, out_tag}, {28'd0, q[0].t});
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (in_valid && in_ready) q.push_back('{p: ref_mult(in1, in2, 1'b0), t: in_tag});
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic push(input logic [9:0] a, input logic [9:0] b, input logic [3:0] t);
        logic rdy;
        in1 = a; in2 = b; in_tag = t; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (n == 49) check("push_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mult", {12'd0, mult}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single op: two-cycle latency.
        push(10'd3, 10'd5, 4'd7);
        cycles(1);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_mult", {12'd0, mult}, 32'd15);
        check("single_tag", {28'd0, out_tag}, 32'd7);
        cycles(1);
        check("single_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back stream at full rate.
        base = popped;
        for (int i = 0; i < 8; i++) begin
            in1 = 10'(i); in2 = 10'(i + 1); in_tag = 4'(i); in_valid = 1'b1;
            #1;
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cycles(4);
        check("b2b_count", 32'(popped - base), 32'd8);

        // Back-pressure: capacity is two.
        out_ready = 1'b0;
        base = popped;
        push(10'd12, 10'd13, 4'd1);
        push(10'd20, 10'd30, 4'd2);
        in1 = 10'd7; in2 = 10'd7; in_tag = 4'd3; in_valid = 1'b1;
        #1;
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("bp_mult_first", {12'd0, mult}, 32'd156);
        cycles(3);
        check("bp_mult_hold", {12'd0, mult}, 32'd156);
        check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycles(4);
        check("bp_count", 32'(popped - base), 32'd2);

        // Full pipeline with out_ready=1: output and input transfer on the same edge.
        out_ready = 1'b0;
        push(10'd100, 10'd200, 4'd4);
        push(10'd50, 10'd3, 4'd5);
        out_ready = 1'b1;
        in1 = 10'd9; in2 = 10'd9; in_tag = 4'd6; in_valid = 1'b1;
        #1;
        check("sim_in_ready", {31'd0, in_ready}, 32'd1);
        check("sim_mult_a", {12'd0, mult}, 32'd20000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim_still_full", {31'd0, out_valid & busy}, 32'd1);
        check("sim_mult_b", {12'd0, mult}, 32'd150);
        cycles(3);

        // Unsigned extreme.
        push(10'h3FF, 10'h3FF, 4'hF);
        cycles(1);
        check("ext_mult", {12'd0, mult}, 32'h000FF801);

        // Signed instance.
        s_in1 = 10'h3FF; s_in2 = 10'h002; s_in_tag = 4'd9; s_in_valid = 1'b1;
        #1;
        check("s_in_ready", {31'd0, s_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_in1 = 10'h200; s_in2 = 10'h200; s_in_tag = 4'd10;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("s_mult_neg", {12'd0, s_mult}, 32'h000FFFFE);
        check("s_mult_neg_model", {12'd0, s_mult}, {12'd0, ref_mult(10'h3FF, 10'h002, 1'b1)});
        check("s_tag_neg", {28'd0, s_out_tag}, 32'd9);
        cycles(1);
        check("s_mult_min", {12'd0, s_mult}, 32'h00040000);
        check("s_tag_min", {28'd0, s_out_tag}, 32'd10);
        cycles(1);
        check("s_busy_after", {31'd0, s_busy | s_out_valid}, 32'd0);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        push(10'd11, 10'd11, 4'd1);
        push(10'd22, 10'd2, 4'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_mult", {12'd0, mult}, 32'd0);
        out_ready = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(3);
        check("post_rst_idle", {31'd0, out_valid | busy}, 32'd0);
        push(10'd31, 10'd4, 4'd8);
        cycles(1);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_mult", {12'd0, mult}, 32'd124);
        check("post_rst_tag", {28'd0, out_tag}, 32'd8);
        cycles(2);
        check("final_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
